// File: rtl/pipearch_line_reader_pkg.sv
// Shared types and constants for the line reader and the operators it feeds.
package pipearch_line_reader_pkg;

    localparam int unsigned DATA_WIDTH = 512;
    localparam int unsigned CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } t_readerstate;

endpackage

// File: rtl/pipearch_line_reader_fifo.sv
// Shared response FIFO: registered read port, rd_valid/rd_data one cycle after rd_en.
// Flow control (never write when full, never read when empty) is the caller's job.
module pipearch_line_reader_fifo
    import pipearch_line_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = DATA_WIDTH,
    parameter int unsigned LOG2_DEPTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]      rd_data_q, rd_data_d;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + LOG2_DEPTH'(wr_en);
        rd_ptr_d   = rd_ptr_q + LOG2_DEPTH'(rd_en);
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? mem_q[rd_ptr_q] : rd_data_q;
    end

    // Reset flushes the FIFO by realigning the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/pipearch_line_reader.sv
// Read-side engine: fetches num_lines consecutive cache lines from base_addr,
// buffers responses and streams them to the operator under almostfull backpressure.
module pipearch_line_reader
    import pipearch_line_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 42,
    parameter int unsigned LOG2_DEPTH = 6,
    parameter int unsigned DATA_WIDTH = pipearch_line_reader_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           num_lines,
    output logic                  op_done,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_almostfull,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  almostfull
);

    localparam int unsigned OCC_WIDTH = LOG2_DEPTH + 1;
    localparam int unsigned DEPTH     = 1 << LOG2_DEPTH;

    t_readerstate          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  received_q, received_d;
    logic [CNT_WIDTH-1:0]  delivered_q, delivered_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  op_done_q, op_done_d;

    logic                  in_fetch_c;
    logic                  fifo_wr_c;
    logic                  fifo_rd_c;
    logic                  can_issue_c;
    logic [CNT_WIDTH-1:0]  inflight_c;
    logic [CNT_WIDTH:0]    committed_c;
    logic                  fifo_rvalid;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    // Credit: every issued request owns a FIFO slot until it is read out,
    // so the FIFO cannot overflow whatever the operator does.
    always_comb begin
        in_fetch_c  = (state_q == FETCH);
        inflight_c  = issued_q - received_q;
        committed_c = (CNT_WIDTH+1)'(occ_q) + (CNT_WIDTH+1)'(inflight_c);
        can_issue_c = in_fetch_c
                   && (issued_q < num_q)
                   && !req_almostfull
                   && (committed_c < (CNT_WIDTH+1)'(DEPTH));
        fifo_wr_c   = in_fetch_c && rsp_valid;
        fifo_rd_c   = in_fetch_c && (occ_q != '0) && !almostfull;
        occ_d       = occ_q + OCC_WIDTH'(fifo_wr_c) - OCC_WIDTH'(fifo_rd_c);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        issued_d    = issued_q;
        received_d  = received_q;
        delivered_d = delivered_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        op_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_start) begin
                    base_d      = base_addr;
                    num_d       = num_lines;
                    issued_d    = '0;
                    received_d  = '0;
                    delivered_d = '0;
                    state_d     = (num_lines == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (can_issue_c) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = base_q + ADDR_WIDTH'(issued_q);
                    issued_d    = issued_q + 32'd1;
                end
                if (fifo_wr_c) begin
                    received_d = received_q + 32'd1;
                end
                if (fifo_rvalid) begin
                    delivered_d = delivered_q + 32'd1;
                    if (delivered_d == num_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // op_done is high for exactly the cycle the FSM sits in DONE.
        op_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            delivered_q <= '0;
            occ_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            op_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            delivered_q <= delivered_d;
            occ_q       <= occ_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            op_done_q   <= op_done_d;
        end
    end

    pipearch_line_reader_fifo #(
        .WIDTH      (DATA_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (fifo_wr_c),
        .wr_data  (rsp_data),
        .rd_en    (fifo_rd_c),
        .rd_valid (fifo_rvalid),
        .rd_data  (fifo_rdata)
    );

    assign op_done   = op_done_q;
    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign rvalid    = fifo_rvalid;
    assign rdata     = fifo_rdata;

endmodule

// File: tb/tb_pipearch_line_reader.sv
// Directed-sequence bench with a randomised in-order memory and a queue-based
// reference of the expected request addresses and delivered lines.
module tb_pipearch_line_reader;
    import pipearch_line_reader_pkg::*;

    localparam int unsigned AW = 42;
    localparam int unsigned DW = DATA_WIDTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_start;
    logic [AW-1:0] base_addr;
    logic [31:0]   num_lines;
    logic          op_done;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_almostfull;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          almostfull;

    pipearch_line_reader dut (
        .clk            (clk),
        .reset          (reset),
        .op_start       (op_start),
        .base_addr      (base_addr),
        .num_lines      (num_lines),
        .op_done        (op_done),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_almostfull (req_almostfull),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .almostfull     (almostfull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } pend_t;

    pend_t         pend_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          op_cyc = 0;
    int          last_due = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic [31:0] salt = 32'h0;
    int          af_mode = 0;
    int          raf_lo = 1;
    int          raf_hi = 0;
    int          spur_at = -1;
    int          req_cnt = 0;
    int          rv_cnt = 0;
    int          done_cnt = 0;
    int          first_req_cyc = 0;
    int          last_req_cyc = 0;
    int          last_rv_cyc = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          raf_viol = 0;
    int          slack = 0;
    int          max_slack = 0;
    logic        af_prev = 1'b0;

    // Address-tagged line contents; salt distinguishes lines of different operations.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [31:0] s);
        logic [DW-1:0] p;
        for (int l = 0; l < int'(DW / 32); l++) begin
            p[32*l +: 32] = (a[31:0] ^ s) + 32'(l) * 32'h9E37_79B9 + {22'h0, a[AW-1:32]};
        end
        return p;
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, play memory, then drive inputs.
    task automatic tick();
        pend_t p;
        int    lat;
        int    due;
        @(negedge clk);
        cyc++;
        if (req_valid === 1'b1) begin
            if (req_almostfull) raf_viol++;
            if (req_cnt == 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            req_cnt++;
            if (exp_addr_q.size() == 0) check_int("unexpected_req", 32'(req_valid), 0);
            else check_line("req_addr", DW'(req_addr), DW'(exp_addr_q.pop_front()));
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            p.data = pat(req_addr, salt);
            p.due  = due;
            pend_q.push_back(p);
        end
        rsp_valid = 1'b0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = p.data;
        end
        if (almostfull && !af_prev) slack = 0;
        if (rvalid === 1'b1) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            if (almostfull) begin
                slack++;
                if (slack > max_slack) max_slack = slack;
            end
            if (exp_data_q.size() == 0) check_int("unexpected_rvalid", 32'(rvalid), 0);
            else check_line("rdata", rdata, exp_data_q.pop_front());
        end
        af_prev = almostfull;
        if (op_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        #1;
        op_cyc++;
        case (af_mode)
            1:       almostfull = 1'b1;
            2:       almostfull = ((op_cyc / 3) % 2) == 1;
            default: almostfull = 1'b0;
        endcase
        req_almostfull = (op_cyc >= raf_lo) && (op_cyc <= raf_hi);
        op_start = (op_cyc == spur_at);
        if (op_cyc == spur_at) begin
            num_lines = 32'd3;
            base_addr = '0;
        end
    endtask

    task automatic start_op(input int n, input logic [AW-1:0] base);
        salt = $urandom;
        exp_data_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + AW'(i));
            exp_data_q.push_back(pat(base + AW'(i), salt));
        end
        req_cnt   = 0;
        rv_cnt    = 0;
        done_cnt  = 0;
        raf_viol  = 0;
        max_slack = 0;
        slack     = 0;
        op_cyc    = 0;
        start_cyc = cyc;
        base_addr = base;
        num_lines = 32'(n);
        op_start  = 1'b1;
        tick();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        check_int({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
        for (int i = 0; i < 4; i++) tick();
        check_int({tag, "_done_once"}, done_cnt, 1);
        check_int({tag, "_exp_drained"}, exp_data_q.size(), 0);
    endtask

    initial begin
        int rv0;
        int rq0;
        reset = 1'b1;
        op_start = 1'b0;
        base_addr = '0;
        num_lines = '0;
        req_almostfull = 1'b0;
        almostfull = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_int("rst_op_done", 32'(op_done), 0);
        check_int("rst_req_valid", 32'(req_valid), 0);
        check_int("rst_rvalid", 32'(rvalid), 0);
        reset = 1'b0;
        tick();

        // Four lines, zero-latency memory, no backpressure.
        lat_min = 0; lat_max = 0;
        start_op(4, AW'(42'h100));
        run_until_done("t1", 200);
        check_int("t1_req_cnt", req_cnt, 4);
        check_int("t1_req_back_to_back", last_req_cyc - first_req_cyc, 3);
        check_int("t1_rv_cnt", rv_cnt, 4);
        check_int("t1_done_after_last", done_cyc, last_rv_cyc + 1);

        // Address wraps at the top of the ADDR_WIDTH space.
        lat_min = 1; lat_max = 3;
        start_op(4, {AW{1'b1}} - AW'(1));
        run_until_done("wrap", 200);
        check_int("wrap_rv_cnt", rv_cnt, 4);

        // Zero-length operation.
        start_op(0, AW'(42'h55));
        run_until_done("t2", 20);
        check_int("t2_done_latency", done_cyc, start_cyc + 1);
        check_int("t2_req_cnt", req_cnt, 0);
        check_int("t2_rv_cnt", rv_cnt, 0);

        // Operator stalled: issue must stop once the FIFO's worth of lines is committed.
        lat_min = 1; lat_max = 5; af_mode = 1;
        start_op(200, AW'(42'h4000));
        for (int i = 0; i < 300; i++) tick();
        check_int("t3_req_capped", req_cnt, 64);
        check_int("t3_no_rvalid", rv_cnt, 0);
        check_int("t3_no_done", done_cnt, 0);
        af_mode = 0;
        run_until_done("t3", 3000);
        check_int("t3_rv_cnt", rv_cnt, 200);
        check_int("t3_req_cnt", req_cnt, 200);

        // Toggling backpressure with random memory latency.
        lat_min = 1; lat_max = 40; af_mode = 2;
        start_op(100, AW'(42'h3_0000_0000));
        run_until_done("t4", 5000);
        check_int("t4_rv_cnt", rv_cnt, 100);
        check_int("t4_slack_le2", 32'(max_slack <= 2), 1);
        af_mode = 0;

        // Request channel blocked for cycles 2..10; a stray op_start mid-fetch is ignored.
        lat_min = 1; lat_max = 4; raf_lo = 2; raf_hi = 10; spur_at = 5;
        start_op(16, AW'(42'h777));
        run_until_done("t5", 1000);
        check_int("t5_no_req_when_blocked", raf_viol, 0);
        check_int("t5_rv_cnt", rv_cnt, 16);
        check_int("t5_req_cnt", req_cnt, 16);
        raf_lo = 1; raf_hi = 0; spur_at = -1;

        // Reset mid-operation with responses still in flight.
        lat_min = 10; lat_max = 20;
        start_op(32, AW'(42'h9000));
        for (int i = 0; i < 3000 && rv_cnt < 7; i++) tick();
        check_int("t6_reached_line7", 32'(rv_cnt >= 7), 1);
        check_int("t6_inflight_at_reset", 32'(pend_q.size() > 0), 1);
        reset = 1'b1;
        tick();
        check_int("t6_rst_req_valid", 32'(req_valid), 0);
        check_int("t6_rst_rvalid", 32'(rvalid), 0);
        check_int("t6_rst_op_done", 32'(op_done), 0);
        tick();
        reset = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        rv0 = rv_cnt;
        rq0 = req_cnt;
        for (int i = 0; i < 500 && pend_q.size() > 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check_int("t6_late_rsp_drained", pend_q.size(), 0);
        check_int("t6_idle_no_rvalid", rv_cnt - rv0, 0);
        check_int("t6_idle_no_req", req_cnt - rq0, 0);
        check_int("t6_no_done_after_abort", done_cnt, 0);
        lat_min = 1; lat_max = 6;
        start_op(2, AW'(42'h2000));
        run_until_done("t6", 500);
        check_int("t6_fresh_rv_cnt", rv_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
